// File: rtl/enc8to3_pkg.sv
// Shared types and helpers for the sticky 8-to-3 priority encoder.
// N_REQ and CODE_W are fixed; the block is not parameterised.
package enc8to3_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [N_REQ-1:0] r;
        r       = '0;
        r[code] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/prienc8to3.sv
// Combinational highest-set-bit encoder: bit 7 has top priority.
// any_o flags a non-zero input; code_o is 0 when nothing is set.
module prienc8to3
    import enc8to3_pkg::*;
(
    input  logic [N_REQ-1:0]  vec_i,
    output logic [CODE_W-1:0] code_o,
    output logic              any_o
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        code_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec_i[i]) begin
                code_o = i[CODE_W-1:0];
            end
        end
        any_o = |vec_i;
    end

endmodule

// File: rtl/enc8to3_arb.sv
// Sticky request capture serialised into 3-bit codes, highest index first.
// Handshake: code is offered while valid=1 and is consumed on the cycle valid & ready.
module enc8to3_arb
    import enc8to3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    input  logic              ready,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [N_REQ-1:0]  pending
);

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic [N_REQ-1:0]    pending_q, pending_d;

    logic [N_REQ-1:0]    new_w;
    logic [N_REQ-1:0]    load_w;
    logic [N_REQ-1:0]    nxt_w;
    logic                hs_w;
    logic [CODE_W-1:0]   load_code_w, nxt_code_w;
    logic                load_any_w, nxt_any_w;

    assign new_w  = req & {N_REQ{en}};
    assign hs_w   = valid_q & ready;
    assign load_w = pending_q | new_w;
    // New captures are OR-ed after the clear so a re-request of the served code survives.
    assign nxt_w  = (pending_q & ~onehot(code_q)) | new_w;

    assign pending_d = hs_w ? nxt_w : load_w;

    prienc8to3 u_pri_load (
        .vec_i  (load_w),
        .code_o (load_code_w),
        .any_o  (load_any_w)
    );

    prienc8to3 u_pri_nxt (
        .vec_i  (nxt_w),
        .code_o (nxt_code_w),
        .any_o  (nxt_any_w)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (load_any_w) begin
                    code_d  = load_code_w;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Without a handshake the presented code is never preempted.
                if (ready) begin
                    if (nxt_any_w) begin
                        code_d = nxt_code_w;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;

    a_valid_matches_state: assert property (@(posedge clk) disable iff (rst)
        valid_q == (state_q == HOLD));

    a_stall_holds_code: assert property (@(posedge clk) disable iff (rst)
        (valid_q && !ready) |=> (valid_q && $stable(code_q)));

endmodule

// File: tb/tb_enc8to3_arb.sv
// Scoreboarded bench for enc8to3_arb: directed scenarios then random traffic,
// checked cycle by cycle against a set-based reference model.
module tb_enc8to3_arb;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic [7:0] req   = 8'h00;
    logic       ready = 1'b0;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {valid, code, pending} after each clock edge.
    logic [11:0] exp_q[$];

    bit         m_pend[8];
    bit         m_valid;
    logic [2:0] m_code;

    always #5 clk = ~clk;

    enc8to3_arb dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .ready   (ready),
        .code    (code),
        .valid   (valid),
        .pending (pending)
    );

    function automatic void check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endfunction

    // Reference: a set of outstanding indices; serve the largest, re-pick after each transfer.
    task automatic model_step(input bit r, input bit e, input logic [7:0] q, input bit rd);
        logic [7:0] p;
        if (r) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
            m_valid = 1'b0;
            m_code  = 3'd0;
        end else begin
            bit take;
            int top;
            take = m_valid && rd;
            if (take) m_pend[m_code] = 1'b0;
            for (int i = 0; i < 8; i++) if (e && q[i]) m_pend[i] = 1'b1;
            if (!m_valid || take) begin
                top = -1;
                for (int i = 0; i < 8; i++) if (m_pend[i]) top = i;
                if (top >= 0) begin
                    m_valid = 1'b1;
                    m_code  = 3'(top);
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        for (int i = 0; i < 8; i++) p[i] = m_pend[i];
        exp_q.push_back({m_valid, m_code, p});
    endtask

    task automatic cycle(input bit r, input bit e, input logic [7:0] q, input bit rd);
        @(negedge clk);
        rst   = r;
        en    = e;
        req   = q;
        ready = rd;
        model_step(r, e, q, rd);
    endtask

    // Monitor: one expected entry per edge, compared just after the edge.
    initial begin
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid",   8'(valid), 8'(e[11]));
                check("code",    8'(code),  8'(e[10:8]));
                check("pending", pending,   e[7:0]);
            end
        end
    end

    initial begin
        // Reset held with all requests active.
        cycle(1, 1, 8'hFF, 0);
        cycle(1, 1, 8'hFF, 0);
        cycle(0, 0, 8'h00, 0);

        // Ordering: 5 then 2, then idle.
        cycle(0, 1, 8'h24, 1);
        cycle(0, 1, 8'h00, 1);
        cycle(0, 1, 8'h00, 1);
        cycle(0, 1, 8'h00, 1);

        // Backpressure: code 2 held while 7 arrives.
        cycle(0, 1, 8'h04, 0);
        cycle(0, 1, 8'h00, 0);
        cycle(0, 1, 8'h80, 0);
        cycle(0, 1, 8'h00, 0);
        cycle(0, 1, 8'h00, 1);
        cycle(0, 1, 8'h00, 1);
        cycle(0, 1, 8'h00, 0);

        // Collision: re-request of 3 in its handshake cycle.
        cycle(0, 1, 8'h08, 0);
        cycle(0, 1, 8'h08, 1);
        cycle(0, 1, 8'h00, 1);
        cycle(0, 1, 8'h00, 0);

        // Enable low ignores requests, then serves captured bits.
        repeat (4) cycle(0, 0, 8'hFF, 1);
        cycle(0, 1, 8'h13, 0);
        cycle(0, 0, 8'hFF, 1);
        repeat (3) cycle(0, 0, 8'h00, 1);

        // Reset in HOLD with 7 and 0 pending.
        cycle(0, 1, 8'h81, 0);
        cycle(1, 1, 8'h00, 0);
        cycle(0, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 1);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            bit         r, e, rd;
            logic [7:0] q;
            r  = ($urandom_range(0, 63) == 0);
            e  = ($urandom_range(0, 3) != 0);
            q  = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            rd = ($urandom_range(0, 2) != 0);
            cycle(r, e, q, rd);
        end
        cycle(0, 0, 8'h00, 1);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
